// File: rtl/alu_issue_stage_if.sv
// ----------------------------------------------------------------------------
// alu_issue_stage_if
// Handshake and data bundle between register read, the issue stage and the
// ALU/execute side.
//   slave  : view taken by alu_issue_stage (consumes instructions, drives ALU op)
//   master : view taken by the environment around the stage
// Signals:
//   in_valid_in / in_ready_out        upstream valid/ready
//   instr_in, pc_in, rs1/rs2_data_in  instruction word, its PC, operand data
//   out_valid_out / out_ready_in      downstream valid/ready
//   alu_ctrl_out, alu_a_out/b_out     ALU operation code and operands
//   rd_out, illegal_out, ill_cnt_out  destination, illegal flag, illegal count
// ----------------------------------------------------------------------------
interface alu_issue_stage_if #(
    parameter int ARCH      = 32,
    parameter int ILL_CNT_W = 8
);
    logic                  in_valid_in;
    logic                  in_ready_out;
    logic [31:0]           instr_in;
    logic [ARCH-1:0]       pc_in;
    logic [ARCH-1:0]       rs1_data_in;
    logic [ARCH-1:0]       rs2_data_in;
    logic                  out_valid_out;
    logic                  out_ready_in;
    logic [3:0]            alu_ctrl_out;
    logic [ARCH-1:0]       alu_a_out;
    logic [ARCH-1:0]       alu_b_out;
    logic [4:0]            rd_out;
    logic                  illegal_out;
    logic [ILL_CNT_W-1:0]  ill_cnt_out;

    modport slave (
        input  in_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, out_ready_in,
        output in_ready_out, out_valid_out, alu_ctrl_out, alu_a_out, alu_b_out,
               rd_out, illegal_out, ill_cnt_out
    );

    modport master (
        output in_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, out_ready_in,
        input  in_ready_out, out_valid_out, alu_ctrl_out, alu_a_out, alu_b_out,
               rd_out, illegal_out, ill_cnt_out
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ----------------------------------------------------------------------------
// alu_issue_stage
// Single-slot decode/issue register between register read and the ALU.
// Decodes RV32I OP, OP-IMM, LUI and AUIPC into an ALU control code plus A/B
// operands, and flags anything else as illegal (still issued, as an ADD of 0+0
// to x0). Valid/ready flow control with a synchronous flush.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   flush_in  kills the held slot and any instruction offered this cycle
//   bus       alu_issue_stage_if.slave (handshakes, operands, decoded op)
// ALU codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SLR=7 SAR=8
// ----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int ILL_CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_in,
    alu_issue_stage_if.slave   bus
);
    localparam int ARCH = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SLR = 4'd7;
    localparam logic [3:0] ALU_SAR = 4'd8;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  f7_zero;
    logic                  f7_alt;
    logic [ARCH-1:0]       imm_i;
    logic [ARCH-1:0]       imm_u;
    logic [ARCH-1:0]       shamt;

    logic [3:0]            dec_ctrl;
    logic [ARCH-1:0]       dec_a;
    logic [ARCH-1:0]       dec_b;
    logic [4:0]            dec_rd;
    logic                  dec_ill;

    logic                  valid_q, valid_d;
    logic [3:0]            ctrl_q, ctrl_d;
    logic [ARCH-1:0]       a_q, a_d;
    logic [ARCH-1:0]       b_q, b_d;
    logic [4:0]            rd_q, rd_d;
    logic                  ill_q, ill_d;
    logic [ILL_CNT_W-1:0]  cnt_q, cnt_d;

    logic                  in_ready;
    logic                  accept;

    // Register indices are resolved upstream; only the data arrives here.
    logic unused_rs_idx;
    assign unused_rs_idx = ^bus.instr_in[19:15];

    assign opcode  = bus.instr_in[6:0];
    assign funct3  = bus.instr_in[14:12];
    assign funct7  = bus.instr_in[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);
    assign imm_i   = {{20{bus.instr_in[31]}}, bus.instr_in[31:20]};
    assign imm_u   = {bus.instr_in[31:12], 12'b0};
    assign shamt   = {27'b0, bus.instr_in[24:20]};

    always_comb begin
        dec_ctrl = ALU_ADD;
        dec_a    = '0;
        dec_b    = '0;
        dec_ill  = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec_a = bus.rs1_data_in;
                dec_b = bus.rs2_data_in;
                unique case (funct3)
                    3'b000: begin
                        if (f7_zero)     dec_ctrl = ALU_ADD;
                        else if (f7_alt) dec_ctrl = ALU_SUB;
                        else             dec_ill  = 1'b1;
                    end
                    3'b001: begin dec_ctrl = ALU_SLL; dec_ill = !f7_zero; end
                    3'b010: begin dec_ctrl = ALU_SLT; dec_ill = !f7_zero; end
                    3'b011: dec_ill = 1'b1;
                    3'b100: begin dec_ctrl = ALU_XOR; dec_ill = !f7_zero; end
                    3'b101: begin
                        if (f7_zero)     dec_ctrl = ALU_SLR;
                        else if (f7_alt) dec_ctrl = ALU_SAR;
                        else             dec_ill  = 1'b1;
                    end
                    3'b110: begin dec_ctrl = ALU_OR;  dec_ill = !f7_zero; end
                    default: begin dec_ctrl = ALU_AND; dec_ill = !f7_zero; end
                endcase
            end
            OPC_OPIMM: begin
                dec_a = bus.rs1_data_in;
                dec_b = imm_i;
                unique case (funct3)
                    3'b000: dec_ctrl = ALU_ADD;
                    3'b001: begin
                        dec_b    = shamt;
                        dec_ctrl = ALU_SLL;
                        dec_ill  = !f7_zero;
                    end
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: dec_ill  = 1'b1;
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: begin
                        dec_b = shamt;
                        if (f7_zero)     dec_ctrl = ALU_SLR;
                        else if (f7_alt) dec_ctrl = ALU_SAR;
                        else             dec_ill  = 1'b1;
                    end
                    3'b110: dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = bus.pc_in;
                dec_b = imm_u;
            end
            default: dec_ill = 1'b1;
        endcase

        // Illegal slots are issued as a harmless ADD 0+0 to x0.
        dec_rd = bus.instr_in[11:7];
        if (dec_ill) begin
            dec_ctrl = ALU_ADD;
            dec_a    = '0;
            dec_b    = '0;
            dec_rd   = '0;
        end
    end

    assign in_ready = !valid_q || bus.out_ready_in;
    assign accept   = bus.in_valid_in && in_ready;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (flush_in) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            a_d     = dec_a;
            b_d     = dec_b;
            rd_d    = dec_rd;
            ill_d   = dec_ill;
            if (dec_ill && (cnt_q != '1)) begin
                cnt_d = cnt_q + ILL_CNT_W'(1);
            end
        end else if (bus.out_ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready_out  = in_ready;
    assign bus.out_valid_out = valid_q;
    assign bus.alu_ctrl_out  = ctrl_q;
    assign bus.alu_a_out     = a_q;
    assign bus.alu_b_out     = b_q;
    assign bus.rd_out        = rd_q;
    assign bus.illegal_out   = ill_q;
    assign bus.ill_cnt_out   = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed vector table, hand-written handshake/flush/reset/saturation
// sequences, and a randomized run against a behavioural decode model with a
// one-entry expected-slot queue.
// ----------------------------------------------------------------------------
module tb_alu_issue_stage;
    localparam int CW = 8;

    localparam logic [3:0] C_ADD = 4'd0;
    localparam logic [3:0] C_SUB = 4'd1;
    localparam logic [3:0] C_AND = 4'd2;
    localparam logic [3:0] C_OR  = 4'd3;
    localparam logic [3:0] C_XOR = 4'd4;
    localparam logic [3:0] C_SLT = 4'd5;
    localparam logic [3:0] C_SLL = 4'd6;
    localparam logic [3:0] C_SLR = 4'd7;
    localparam logic [3:0] C_SAR = 4'd8;

    localparam logic [31:0] I_SLTU = 32'h003130B3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_in = 1'b0;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.ARCH(32), .ILL_CNT_W(CW)) bus ();

    alu_issue_stage #(.ILL_CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_in (flush_in),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        dec_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input dec_t e);
        chk({tag, "_valid"}, 32'(bus.out_valid_out), 32'd1);
        chk({tag, "_ctrl"},  32'(bus.alu_ctrl_out), 32'(e.ctrl));
        chk({tag, "_a"},     bus.alu_a_out, e.a);
        chk({tag, "_b"},     bus.alu_b_out, e.b);
        chk({tag, "_rd"},    32'(bus.rd_out), 32'(e.rd));
        chk({tag, "_ill"},   32'(bus.illegal_out), 32'(e.ill));
    endtask

    // Behavioural decode: an instruction is named by its {funct7,funct3}
    // or funct3 pattern and mapped directly to the ALU operation.
    function automatic dec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2);
        dec_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        d = '{ctrl: C_ADD, a: 32'd0, b: 32'd0, rd: ins[11:7], ill: 1'b0};
        case (ins[6:0])
            7'b0110011: begin
                d.a = r1;
                d.b = r2;
                case ({f7, f3})
                    {7'h00, 3'd0}: d.ctrl = C_ADD;
                    {7'h20, 3'd0}: d.ctrl = C_SUB;
                    {7'h00, 3'd1}: d.ctrl = C_SLL;
                    {7'h00, 3'd2}: d.ctrl = C_SLT;
                    {7'h00, 3'd4}: d.ctrl = C_XOR;
                    {7'h00, 3'd5}: d.ctrl = C_SLR;
                    {7'h20, 3'd5}: d.ctrl = C_SAR;
                    {7'h00, 3'd6}: d.ctrl = C_OR;
                    {7'h00, 3'd7}: d.ctrl = C_AND;
                    default:       d.ill  = 1'b1;
                endcase
            end
            7'b0010011: begin
                d.a = r1;
                d.b = {{20{ins[31]}}, ins[31:20]};
                case (f3)
                    3'd0: d.ctrl = C_ADD;
                    3'd2: d.ctrl = C_SLT;
                    3'd4: d.ctrl = C_XOR;
                    3'd6: d.ctrl = C_OR;
                    3'd7: d.ctrl = C_AND;
                    3'd1: begin
                        d.b = {27'd0, ins[24:20]};
                        if (f7 == 7'h00) d.ctrl = C_SLL;
                        else             d.ill  = 1'b1;
                    end
                    3'd5: begin
                        d.b = {27'd0, ins[24:20]};
                        if (f7 == 7'h00)      d.ctrl = C_SLR;
                        else if (f7 == 7'h20) d.ctrl = C_SAR;
                        else                  d.ill  = 1'b1;
                    end
                    default: d.ill = 1'b1;
                endcase
            end
            7'b0110111: begin
                d.b = {ins[31:12], 12'h000};
            end
            7'b0010111: begin
                d.a = pc;
                d.b = {ins[31:12], 12'h000};
            end
            default: d.ill = 1'b1;
        endcase
        if (d.ill) d = '{ctrl: C_ADD, a: 32'd0, b: 32'd0, rd: 5'd0, ill: 1'b1};
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w   = $urandom();
        sel = $urandom_range(0, 9);
        if (sel <= 3)      w[6:0] = 7'b0110011;
        else if (sel <= 6) w[6:0] = 7'b0010011;
        else if (sel == 7) w[6:0] = 7'b0110111;
        else if (sel == 8) w[6:0] = 7'b0010111;
        if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic rdy);
        bus.in_valid_in  = v;
        bus.instr_in     = ins;
        bus.pc_in        = pc;
        bus.rs1_data_in  = r1;
        bus.rs2_data_in  = r2;
        bus.out_ready_in = rdy;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        flush_in = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[16];
    dec_t exp_q[$];

    initial begin
        vt[0]  = '{32'hFFB10093, 32'h0,   32'h7,        32'h55, '{C_ADD, 32'h7,        32'hFFFFFFFB, 5'd1,  1'b0}};
        vt[1]  = '{32'h402081B3, 32'h0,   32'h20,       32'h8,  '{C_SUB, 32'h20,       32'h8,        5'd3,  1'b0}};
        vt[2]  = '{32'h40335293, 32'h0,   32'h80000000, 32'h9,  '{C_SAR, 32'h80000000, 32'h3,        5'd5,  1'b0}};
        vt[3]  = '{32'h123453B7, 32'h40,  32'h11,       32'h22, '{C_ADD, 32'h0,        32'h12345000, 5'd7,  1'b0}};
        vt[4]  = '{32'h00001097, 32'h100, 32'h33,       32'h44, '{C_ADD, 32'h100,      32'h1000,     5'd1,  1'b0}};
        vt[5]  = '{I_SLTU,       32'h0,   32'h5,        32'h6,  '{C_ADD, 32'h0,        32'h0,        5'd0,  1'b1}};
        vt[6]  = '{32'h00C5E533, 32'h0,   32'hF0F0,     32'h0F0F, '{C_OR, 32'hF0F0,    32'h0F0F,     5'd10, 1'b0}};
        vt[7]  = '{32'h00208033, 32'h0,   32'h1,        32'h2,  '{C_ADD, 32'h1,        32'h2,        5'd0,  1'b0}};
        vt[8]  = '{32'h41F21213, 32'h0,   32'h7,        32'h7,  '{C_ADD, 32'h0,        32'h0,        5'd0,  1'b1}};
        vt[9]  = '{32'h01F25213, 32'h0,   32'hDEAD,     32'h1,  '{C_SLR, 32'hDEAD,     32'd31,       5'd4,  1'b0}};
        vt[10] = '{32'h0000006F, 32'h0,   32'h7,        32'h7,  '{C_ADD, 32'h0,        32'h0,        5'd0,  1'b1}};
        vt[11] = '{32'h40209033, 32'h0,   32'h7,        32'h7,  '{C_ADD, 32'h0,        32'h0,        5'd0,  1'b1}};
        vt[12] = '{32'h7F03F313, 32'h0,   32'hABCD,     32'h0,  '{C_AND, 32'hABCD,     32'h7F0,      5'd6,  1'b0}};
        vt[13] = '{32'hFFF12093, 32'h0,   32'h3,        32'h0,  '{C_SLT, 32'h3,        32'hFFFFFFFF, 5'd1,  1'b0}};
        vt[14] = '{32'h0041C133, 32'h0,   32'h1234,     32'h4321, '{C_XOR, 32'h1234,   32'h4321,     5'd2,  1'b0}};
        vt[15] = '{32'h4041D133, 32'h0,   32'h80,       32'h4,  '{C_SAR, 32'h80,       32'h4,        5'd2,  1'b0}};

        // Reset state.
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        #2;
        chk("rst_valid",    32'(bus.out_valid_out), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready_out), 32'd1);
        chk("rst_ctrl",     32'(bus.alu_ctrl_out), 32'd0);
        chk("rst_a",        bus.alu_a_out, 32'd0);
        chk("rst_cnt",      32'(bus.ill_cnt_out), 32'd0);
        do_reset();
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready_out), 32'd1);

        // Directed table, issued back to back with the sink always ready.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vt[i].instr, vt[i].pc, vt[i].rs1, vt[i].rs2, 1'b1);
            #1 chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready_out), 32'd1);
            tick();
            check_out($sformatf("vec%0d", i), vt[i].exp);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        chk("table_drain_valid", 32'(bus.out_valid_out), 32'd0);
        chk("table_ill_cnt", 32'(bus.ill_cnt_out), 32'd4);

        // Backpressure: slot held for 3 cycles, then drain-and-fill.
        do_reset();
        drive(1'b1, vt[0].instr, vt[0].pc, vt[0].rs1, vt[0].rs2, 1'b1);
        tick();
        check_out("bp_first", vt[0].exp);
        drive(1'b1, vt[1].instr, vt[1].pc, vt[1].rs1, vt[1].rs2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready_out), 32'd0);
            tick();
            check_out($sformatf("bp_hold%0d", i), vt[0].exp);
        end
        bus.out_ready_in = 1'b1;
        #1 chk("bp_fill_in_ready", 32'(bus.in_ready_out), 32'd1);
        tick();
        check_out("bp_fill", vt[1].exp);
        drive(1'b1, vt[2].instr, vt[2].pc, vt[2].rs1, vt[2].rs2, 1'b1);
        tick();
        check_out("bp_next", vt[2].exp);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        chk("bp_empty", 32'(bus.out_valid_out), 32'd0);

        // Flush beats a simultaneous accept; the illegal is not counted.
        drive(1'b1, I_SLTU, 32'd0, 32'd0, 32'd0, 1'b1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("flush_acc_valid", 32'(bus.out_valid_out), 32'd0);
        chk("flush_acc_cnt",   32'(bus.ill_cnt_out), 32'd0);
        // Flush of a slot held under backpressure.
        drive(1'b1, vt[3].instr, vt[3].pc, vt[3].rs1, vt[3].rs2, 1'b0);
        tick();
        check_out("flush_hold", vt[3].exp);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("flush_hold_valid", 32'(bus.out_valid_out), 32'd0);

        // Asynchronous reset while a slot is held.
        drive(1'b1, I_SLTU, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("arst_pre_valid", 32'(bus.out_valid_out), 32'd1);
        chk("arst_pre_cnt",   32'(bus.ill_cnt_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid_out), 32'd0);
        chk("arst_ill",   32'(bus.illegal_out), 32'd0);
        chk("arst_cnt",   32'(bus.ill_cnt_out), 32'd0);
        do_reset();

        // Illegal counter saturation.
        drive(1'b1, I_SLTU, 32'd0, 32'h9, 32'h9, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                chk($sformatf("sat_cnt_%0d", i), 32'(bus.ill_cnt_out), (i < 255) ? 32'(i) : 32'd255);
            end
        end
        chk("sat_ill", 32'(bus.illegal_out), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);

        // Randomized run against the behavioural model.
        do_reset();
        begin
            int unsigned m_cnt;
            dec_t e_in;
            logic rdy_now;
            m_cnt = 0;
            exp_q.delete();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                drive(($urandom_range(0, 3) != 0), rand_instr(), $urandom(), $urandom(), $urandom(),
                      ($urandom_range(0, 3) != 0));
                flush_in = ($urandom_range(0, 19) == 0);
                #1;
                rdy_now = (exp_q.size() == 0) || bus.out_ready_in;
                chk("rnd_in_ready", 32'(bus.in_ready_out), 32'(rdy_now));
                e_in = ref_dec(bus.instr_in, bus.pc_in, bus.rs1_data_in, bus.rs2_data_in);
                @(posedge clk);
                #1;
                if (flush_in) begin
                    exp_q.delete();
                end else begin
                    if (bus.out_ready_in && exp_q.size() != 0) void'(exp_q.pop_front());
                    if (bus.in_valid_in && rdy_now) begin
                        exp_q.push_back(e_in);
                        if (e_in.ill && m_cnt < 255) m_cnt++;
                    end
                end
                if (exp_q.size() != 0) check_out("rnd", exp_q[0]);
                else chk("rnd_valid", 32'(bus.out_valid_out), 32'd0);
                chk("rnd_cnt", 32'(bus.ill_cnt_out), m_cnt);
            end
        end
        flush_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
